// File: rtl/mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul
//  Description : 32x32 -> 64-bit two-stage pipelined multiplier with a
//                per-operation signed/unsigned mode. Both operands are
//                extended to 33-bit signed values, stage 1 runs before the
//                pipeline register, stage 2 after it, and result is driven
//                combinationally from that register (latency one edge,
//                one new operation accepted on every edge).
//
//  Ports       : mul_clk    in   1   clock, rising edge
//                reset      in   1   synchronous, active-high
//                mul_signed in   1   1 = two's-complement operands
//                x          in  32   multiplicand
//                y          in  32   multiplier
//                result     out 64   low 64 bits of the product of the
//                                    operands sampled on the previous edge
//
//  Config      : MUL_BOOTH_WALLACE_EN
//                  defined   - radix-4 Booth partial products reduced by a
//                              carry-save (full-adder) tree to a sum/carry
//                              pair; stage 2 adds the pair.
//                  undefined - extended operands are registered; stage 2 is
//                              a behavioral signed multiply.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mul (
    input  logic        mul_clk,
    input  logic        reset,
    input  logic        mul_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] result
);

    // Operand extension: the extra MSB carries the sign only in signed mode,
    // so a single signed datapath serves both modes.
    logic [32:0] w_xe;
    logic [32:0] w_ye;

    assign w_xe = {mul_signed & x[31], x};
    assign w_ye = {mul_signed & y[31], y};

`ifdef MUL_BOOTH_WALLACE_EN

    localparam int c_NUM_PP   = 17;           // radix-4 groups over 34 bits
    localparam int c_NUM_ROWS = c_NUM_PP + 1; // plus the negation-bit row
    localparam int c_LEVELS   = 6;            // 18->12->8->6->4->3->2

    logic [63:0] w_sum;
    logic [63:0] w_carry;
    logic [63:0] r_sum;
    logic [63:0] r_carry;

    always_comb begin
        logic [34:0] ye_b;
        logic [63:0] xe64;
        logic [63:0] mag;
        logic [63:0] corr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [2:0]  grp;
        logic        neg;
        int          n;
        int          nt;
        logic [63:0] rows [0:c_NUM_ROWS-1];
        logic [63:0] nxt  [0:c_NUM_ROWS-1];

        ye_b = {w_ye[32], w_ye, 1'b0};
        xe64 = {{31{w_xe[32]}}, w_xe};
        corr = '0;
        mag  = '0;
        neg  = 1'b0;
        grp  = '0;
        a    = '0;
        b    = '0;
        c    = '0;

        // Booth recoding. A negative multiple is formed as the one's
        // complement here; the +1 lands in the correction row at bit 2i.
        for (int i = 0; i < c_NUM_PP; i++) begin
            grp = ye_b[2*i +: 3];
            case (grp)
                3'b001, 3'b010: begin mag = xe64;       neg = 1'b0; end
                3'b011:         begin mag = xe64 << 1;  neg = 1'b0; end
                3'b100:         begin mag = xe64 << 1;  neg = 1'b1; end
                3'b101, 3'b110: begin mag = xe64;       neg = 1'b1; end
                default:        begin mag = '0;         neg = 1'b0; end
            endcase
            rows[i] = (neg ? ~mag : mag) << (2 * i);
            corr[2*i] = neg;
        end
        rows[c_NUM_PP] = corr;

        // Carry-save reduction: each level compresses every complete triple
        // of rows with full adders and passes the remainder straight through.
        // Bits carried out of bit 63 are dropped, which is exact modulo 2^64.
        n = c_NUM_ROWS;
        for (int l = 0; l < c_LEVELS; l++) begin
            nt = n / 3;
            for (int r = 0; r < c_NUM_ROWS; r++) begin
                nxt[r] = '0;
            end
            for (int t = 0; t < c_NUM_ROWS / 3; t++) begin
                if (t < nt) begin
                    a = rows[3*t];
                    b = rows[3*t+1];
                    c = rows[3*t+2];
                    nxt[2*t]   = a ^ b ^ c;
                    nxt[2*t+1] = ((a & b) | (a & c) | (b & c)) << 1;
                end
            end
            for (int r = 0; r < c_NUM_ROWS; r++) begin
                if ((r >= 3 * nt) && (r < n)) begin
                    nxt[r-nt] = rows[r];
                end
            end
            for (int r = 0; r < c_NUM_ROWS; r++) begin
                rows[r] = nxt[r];
            end
            n = 2 * nt + (n % 3);
        end

        w_sum   = rows[0];
        w_carry = rows[1];
    end

    // Clearing both vectors makes the stage-2 sum read zero during reset.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_sum   <= '0;
            r_carry <= '0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry;
        end
    end

    assign result = r_sum + r_carry;

`else

    logic [32:0]        r_xe;
    logic [32:0]        r_ye;
    logic signed [63:0] w_xe64;
    logic signed [63:0] w_ye64;

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_xe <= '0;
            r_ye <= '0;
        end else begin
            r_xe <= w_xe;
            r_ye <= w_ye;
        end
    end

    // Sign-extending to 64 bits keeps the multiply at the result width;
    // the low 64 bits equal those of the full 66-bit product.
    assign w_xe64 = {{31{r_xe[32]}}, r_xe};
    assign w_ye64 = {{31{r_ye[32]}}, r_ye};
    assign result = w_xe64 * w_ye64;

`endif

endmodule
`default_nettype wire

// File: tb/tb_mul.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul
//  Description : Self-checking bench for mul. Directed corner vectors,
//                per-cycle mode alternation, input-hold behaviour, reset
//                mid-stream, and a random back-to-back stream against a
//                66-bit reference product.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul;

    logic        clk;
    logic        reset;
    logic        mul_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] result;

    int errors;
    int checks;

    mul dut (
        .mul_clk    (clk),
        .reset      (reset),
        .mul_signed (mul_signed),
        .x          (x),
        .y          (y),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full 66-bit signed product of the extended operands.
    function automatic logic [63:0] model(input logic ms, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [65:0] ae;
        logic signed [65:0] be;
        logic signed [65:0] p;
        ae = {{33{ms & a[31]}}, a};
        be = {{33{ms & b[31]}}, b};
        p  = ae * be;
        return p[63:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        mul_signed = 1'b1;
        x          = 32'hDEADBEEF;
        y          = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (result !== 64'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: result=%h required=%h", i, result, 64'h0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic        ms  [0:9];
        logic [31:0] xv  [0:9];
        logic [31:0] yv  [0:9];
        logic [63:0] ev  [0:9];
        ms[0]=0; xv[0]=32'hFFFFFFFF; yv[0]=32'hFFFFFFFF; ev[0]=64'hFFFFFFFE00000001;
        ms[1]=1; xv[1]=32'hFFFFFFFF; yv[1]=32'hFFFFFFFF; ev[1]=64'h0000000000000001;
        ms[2]=1; xv[2]=32'h80000000; yv[2]=32'h80000000; ev[2]=64'h4000000000000000;
        ms[3]=1; xv[3]=32'h80000000; yv[3]=32'h00000001; ev[3]=64'hFFFFFFFF80000000;
        ms[4]=0; xv[4]=32'h80000000; yv[4]=32'h00000001; ev[4]=64'h0000000080000000;
        ms[5]=0; xv[5]=32'h00000007; yv[5]=32'h00000009; ev[5]=64'h000000000000003F;
        ms[6]=1; xv[6]=32'hFFFFFFFF; yv[6]=32'h00000002; ev[6]=64'hFFFFFFFFFFFFFFFE;
        ms[7]=0; xv[7]=32'hFFFFFFFF; yv[7]=32'h00000002; ev[7]=64'h00000001FFFFFFFE;
        ms[8]=1; xv[8]=32'h7FFFFFFF; yv[8]=32'h80000000; ev[8]=64'hC000000080000000;
        ms[9]=0; xv[9]=32'h00000000; yv[9]=32'hFFFFFFFF; ev[9]=64'h0000000000000000;
        for (int i = 0; i < 10; i++) begin
            mul_signed = ms[i];
            x          = xv[i];
            y          = yv[i];
            step();
            checks++;
            if (result !== ev[i]) begin
                errors++;
                $display("FAIL directed[%0d] ms=%0d x=%h y=%h: result=%h required=%h",
                         i, ms[i], xv[i], yv[i], result, ev[i]);
            end
        end
    endtask

    // Same operands, mode flipped every edge.
    task automatic test_mode_alternate();
        logic [63:0] exp;
        x = 32'h80000000;
        y = 32'h00000001;
        for (int i = 0; i < 4; i++) begin
            mul_signed = ~i[0];
            exp = i[0] ? 64'h0000000080000000 : 64'hFFFFFFFF80000000;
            step();
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL mode_alt[%0d]: result=%h required=%h", i, result, exp);
            end
        end
    endtask

    // Inputs changing between edges must not disturb result.
    task automatic test_hold();
        mul_signed = 1'b0;
        x = 32'd1000;
        y = 32'd3000;
        step();
        mul_signed = 1'b1;
        x = 32'hFFFFFFFF;
        y = 32'd5;
        #2;
        checks++;
        if (result !== 64'd3000000) begin
            errors++;
            $display("FAIL hold_between_edges: result=%h required=%h", result, 64'd3000000);
        end
        step();
        checks++;
        if (result !== 64'hFFFFFFFFFFFFFFFB) begin
            errors++;
            $display("FAIL hold_next_edge: result=%h required=%h", result, 64'hFFFFFFFFFFFFFFFB);
        end
    endtask

    task automatic test_reset_midstream();
        mul_signed = 1'b0;
        x = 32'd7;
        y = 32'd9;
        step();
        checks++;
        if (result !== 64'd63) begin
            errors++;
            $display("FAIL midreset_pre: result=%h required=%h", result, 64'd63);
        end
        reset = 1'b1;
        step();
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL midreset_during: result=%h required=%h", result, 64'h0);
        end
        reset = 1'b0;
        step();
        checks++;
        if (result !== 64'd63) begin
            errors++;
            $display("FAIL midreset_after: result=%h required=%h", result, 64'd63);
        end
    endtask

    task automatic test_back_to_back();
        logic        ms;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        for (int i = 0; i < 3000; i++) begin
            ms = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            // Bias some vectors toward extreme operands.
            if (i % 7 == 0) a = {a[31], 31'h0};
            if (i % 11 == 0) b = {32{b[0]}};
            mul_signed = ms;
            x          = a;
            y          = b;
            exp        = model(ms, a, b);
            step();
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL random[%0d] xe=%h ye=%h: result=%h required=%h",
                         i, {ms & a[31], a}, {ms & b[31], b}, result, exp);
                break;
            end
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b1;
        mul_signed = 1'b0;
        x          = '0;
        y          = '0;
        test_reset();
        test_directed();
        test_mode_alternate();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
